// File: rtl/sobel_thr_ctrl.sv
// Per-frame edge counter and threshold controller for the Sobel filter.
// Define SOBEL_THR_STATS_EN to drive o_edge_count / o_frame_done.
module sobel_thr_ctrl #(
  parameter int unsigned THR_INIT = 200,
  parameter int unsigned THR_MIN  = 16,
  parameter int unsigned THR_MAX  = 2040,
  parameter int unsigned THR_STEP = 8,
  parameter int unsigned CNT_W    = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vsyn,
  input  logic             i_en,
  input  logic             i_edge,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [1:0]       i_cfg_addr,
  input  logic [CNT_W-1:0] i_cfg_data,
  output logic [10:0]      o_threshold,
  output logic             o_thr_update,
  output logic [CNT_W-1:0] o_edge_count,
  output logic             o_frame_done
);

  typedef enum logic [1:0] {
    S_SYNC,
    S_COUNT,
    S_EVAL,
    S_APPLY
  } state_e;

  localparam logic [11:0] MIN12  = 12'(THR_MIN);
  localparam logic [11:0] MAX12  = 12'(THR_MAX);
  localparam logic [11:0] STEP12 = 12'(THR_STEP);
  localparam logic [11:0] DNLIM  = 12'(THR_MIN + THR_STEP);

  state_e           state_q, state_d;
  logic             vsyn_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_up;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [10:0]      man_q;
  logic [CNT_W-1:0] lo_q, hi_q;
  logic             auto_q;
  logic [10:0]      nxt_q, nxt_thr, thr_q;
  logic             upd_q;
  logic             cfg_ready;
  logic             cfg_we;
  logic [11:0]      thr12, up12, man12;

  assign rise   = i_vsyn & ~vsyn_q;
  assign cnt_up = (i_en && i_edge && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign cfg_we = i_cfg_valid & cfg_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    cfg_ready = 1'b1;
    unique case (state_q)
      S_SYNC: begin
        cnt_d = '0;
        if (rise) state_d = S_COUNT;
      end
      S_COUNT: begin
        cnt_d = cnt_up;
        if (rise) begin
          snap_d  = cnt_up;
          cnt_d   = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        cnt_d     = cnt_up;
        cfg_ready = 1'b0;
        state_d   = S_APPLY;
      end
      S_APPLY: begin
        cnt_d     = cnt_up;
        cfg_ready = 1'b0;
        state_d   = S_COUNT;
      end
      default: state_d = S_SYNC;
    endcase
  end

  assign thr12 = {1'b0, thr_q};
  assign up12  = thr12 + STEP12;
  assign man12 = {1'b0, man_q};

  // 12-bit arithmetic keeps the step sums clear of overflow before clamping
  always_comb begin
    nxt_thr = thr_q;
    if (!auto_q) begin
      if (man12 < MIN12)      nxt_thr = 11'(MIN12);
      else if (man12 > MAX12) nxt_thr = 11'(MAX12);
      else                    nxt_thr = man_q;
    end else if (snap_q > hi_q) begin
      nxt_thr = (up12 > MAX12) ? 11'(MAX12) : 11'(up12);
    end else if (snap_q < lo_q) begin
      nxt_thr = (thr12 <= DNLIM) ? 11'(MIN12) : 11'(thr12 - STEP12);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_SYNC;
      vsyn_q  <= 1'b0;
      cnt_q   <= '0;
      snap_q  <= '0;
      nxt_q   <= 11'(THR_INIT);
      thr_q   <= 11'(THR_INIT);
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vsyn_q  <= i_vsyn;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      upd_q   <= (state_q == S_APPLY);
      if (state_q == S_EVAL)  nxt_q <= nxt_thr;
      if (state_q == S_APPLY) thr_q <= nxt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      man_q  <= 11'(THR_INIT);
      lo_q   <= '0;
      hi_q   <= '1;
      auto_q <= 1'b0;
    end else if (cfg_we) begin
      unique case (i_cfg_addr)
        2'd0: man_q  <= i_cfg_data[10:0];
        2'd1: lo_q   <= i_cfg_data;
        2'd2: hi_q   <= i_cfg_data;
        2'd3: auto_q <= i_cfg_data[0];
        default: ;
      endcase
    end
  end

`ifdef SOBEL_THR_STATS_EN
  logic [CNT_W-1:0] ec_q;
  logic             fd_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ec_q <= '0;
      fd_q <= 1'b0;
    end else begin
      fd_q <= (state_q == S_EVAL);
      if (state_q == S_EVAL) ec_q <= snap_q;
    end
  end

  assign o_edge_count = ec_q;
  assign o_frame_done = fd_q;
`else
  assign o_edge_count = '0;
  assign o_frame_done = 1'b0;
`endif

  assign o_cfg_ready  = cfg_ready;
  assign o_threshold  = thr_q;
  assign o_thr_update = upd_q;

endmodule

// File: tb/tb_sobel_thr_ctrl.sv
// Directed bench for sobel_thr_ctrl: manual/auto threshold, clamps,
// config timing and async reset.
`timescale 1ns/1ps
module tb_sobel_thr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsyn, en, edg;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic [10:0] thr;
  logic        thr_upd;
  logic [23:0] edge_cnt;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;
  int cur_thr = 200;

  always #5 clk = ~clk;

  sobel_thr_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_vsyn       (vsyn),
    .i_en         (en),
    .i_edge       (edg),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_data   (cfg_data),
    .o_threshold  (thr),
    .o_thr_update (thr_upd),
    .o_edge_count (edge_cnt),
    .o_frame_done (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [23:0] d);
    int t;
    t = 0;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    while (!cfg_ready && t < 10) begin
      step();
      t++;
    end
    check("cfg_rdy", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic sync_rise(input string tag);
    vsyn = 1'b1;
    step();
    vsyn = 1'b0;
    step();
    step();
    check({tag, "_sync_thr"}, 32'(thr), 32'(cur_thr));
    check({tag, "_sync_upd"}, 32'(thr_upd), 0);
  endtask

  task automatic frame(input string tag, input int n, input bit coin,
                       input int exp_thr);
    int exp_cnt;
    exp_cnt = n + int'(coin);
    en  = 1'b1;
    edg = 1'b1;
    repeat (n) step();
    en   = coin;
    edg  = coin;
    vsyn = 1'b1;
    step();
    en   = 1'b0;
    edg  = 1'b0;
    vsyn = 1'b0;
    step();
`ifdef SOBEL_THR_STATS_EN
    check({tag, "_fdone"}, 32'(frame_done), 1);
    check({tag, "_ecnt"}, 32'(edge_cnt), 32'(exp_cnt));
`else
    check({tag, "_fdone"}, 32'(frame_done), 0);
    check({tag, "_ecnt"}, 32'(edge_cnt), 0);
`endif
    check({tag, "_thr_old"}, 32'(thr), 32'(cur_thr));
    step();
    check({tag, "_thr"}, 32'(thr), 32'(exp_thr));
    check({tag, "_upd"}, 32'(thr_upd), 1);
    step();
    check({tag, "_upd_end"}, 32'(thr_upd), 0);
    cur_thr = exp_thr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    vsyn      = 1'b0;
    en        = 1'b0;
    edg       = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    repeat (2) step();
    check("rst_thr", 32'(thr), 200);
    check("rst_upd", 32'(thr_upd), 0);
    check("rst_rdy", 32'(cfg_ready), 1);
    check("rst_ecnt", 32'(edge_cnt), 0);
    check("rst_fdone", 32'(frame_done), 0);
    rst_n = 1'b1;
    step();

    // manual mode
    cfg_wr(2'd0, 24'd300);
    sync_rise("man");
    frame("man", 10, 1'b0, 300);

    // auto mode window
    cfg_wr(2'd0, 24'd200);
    frame("man200", 0, 1'b0, 200);
    cfg_wr(2'd1, 24'd100);
    cfg_wr(2'd2, 24'd200);
    cfg_wr(2'd3, 24'd1);
    frame("auto_hi", 250, 1'b0, 208);
    frame("auto_lo", 50, 1'b0, 200);
    frame("auto_hold", 150, 1'b0, 200);
    frame("coin", 100, 1'b1, 200);

    // clamps
    cfg_wr(2'd3, 24'd0);
    cfg_wr(2'd0, 24'd2040);
    frame("man2040", 0, 1'b0, 2040);
    cfg_wr(2'd2, 24'd0);
    cfg_wr(2'd3, 24'd1);
    frame("clamp_max", 5, 1'b0, 2040);
    cfg_wr(2'd3, 24'd0);
    cfg_wr(2'd0, 24'd16);
    frame("man16", 0, 1'b0, 16);
    cfg_wr(2'd1, 24'd1000);
    cfg_wr(2'd2, 24'd2000);
    cfg_wr(2'd3, 24'd1);
    frame("clamp_min", 3, 1'b0, 16);
    cfg_wr(2'd1, 24'd50);
    cfg_wr(2'd2, 24'd10);
    frame("lo_gt_hi", 20, 1'b0, 24);
    cfg_wr(2'd3, 24'd0);
    cfg_wr(2'd0, 24'd5);
    frame("man5", 0, 1'b0, 16);

    // mid-frame write, then a write held across EVAL/APPLY
    en  = 1'b1;
    edg = 1'b1;
    repeat (5) step();
    cfg_wr(2'd0, 24'd240);
    check("mid_thr0", 32'(thr), 16);
    step();
    check("mid_thr1", 32'(thr), 16);
    en   = 1'b0;
    edg  = 1'b0;
    vsyn = 1'b1;
    step();
    vsyn      = 1'b0;
    cfg_valid = 1'b1;
    cfg_addr  = 2'd0;
    cfg_data  = 24'd100;
    check("rdy_eval", 32'(cfg_ready), 0);
    step();
    check("rdy_apply", 32'(cfg_ready), 0);
    check("mid_thr2", 32'(thr), 16);
    step();
    check("mid_thr3", 32'(thr), 240);
    check("mid_upd", 32'(thr_upd), 1);
    check("rdy_back", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    cur_thr   = 240;
    frame("held_wr", 0, 1'b0, 100);

    // async reset mid-frame
    cfg_wr(2'd0, 24'd240);
    frame("pre_rst", 7, 1'b0, 240);
    en  = 1'b1;
    edg = 1'b1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_thr", 32'(thr), 200);
    check("arst_upd", 32'(thr_upd), 0);
    check("arst_rdy", 32'(cfg_ready), 1);
    check("arst_ecnt", 32'(edge_cnt), 0);
    en  = 1'b0;
    edg = 1'b0;
    step();
    rst_n   = 1'b1;
    cur_thr = 200;
    step();
    cfg_wr(2'd0, 24'd300);
    sync_rise("post_rst");
    frame("post_rst", 4, 1'b0, 300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
